rgb2gray_stream: RTL and testbench
==================================

Name: rgb2gray_stream

Overview:
- Downstream stage of the demosaic engine. Starts once the engine's done is high, then scans the three filled 128x128 R/G/B planes in raster order.
- Converts each pixel to 8-bit luma and streams it out over a valid/ready interface, with out_last on the final pixel.
- Absorbs output backpressure through a small output FIFO and credit-gated read issue.

Parameters:
- IMG_W, 128, pixels per row (power of two).
- IMG_H, 128, rows per frame.
- ADDR_W, 14, plane address width; address = {row, col}.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 3).
- COEF_R, 77, red luma weight (Q0.8).
- COEF_G, 150, green luma weight (Q0.8).
- COEF_B, 29, blue luma weight (Q0.8); COEF_R + COEF_G + COEF_B = 256.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; connects to demosaic done
- rd_addr  out  ADDR_W  read address, shared by R/G/B planes
- rdata_r  in  8  R plane data for the current rd_addr (combinational read, same cycle)
- rdata_g  in  8  G plane data, same timing
- rdata_b  in  8  B plane data, same timing
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when high with out_valid
- out_data  out  8  luma Y
- out_last  out  1  high with the final pixel (address IMG_W*IMG_H-1)
- busy  out  1  high in RUN and DRAIN
- done  out  1  sticky frame-complete flag

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - rd_addr = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0, done = 0.
  - FIFO empty, pipeline valid bits cleared, state IDLE.
- Reset mid-frame aborts the frame completely; no partial output survives.
- FSM states:
  - IDLE -> RUN on the edge that samples start = 1.
  - RUN -> DRAIN after the issue of address IMG_W*IMG_H-1.
  - DRAIN -> DONE on the edge where the out_last handshake occurs.
  - DONE is terminal until reset. start is ignored outside IDLE.
- Issue (RUN only):
  - rd_addr is a registered counter. The read is issued when credit is available: fifo_count + inflight < FIFO_DEPTH. inflight counts pipeline stage S1 plus the entry being written this cycle.
  - On issue, rd_addr increments. No wrap: the counter holds at the last address.
  - If no credit is available, rd_addr holds and no pixel is issued.
- Pipeline:
  - S1 registers the three products: R*COEF_R, G*COEF_G, B*COEF_B, each 16-bit.
  - S2 computes sum = pR + pG + pB + 128 (16-bit, cannot overflow; max 65408), then Y = sum[15:8]. Y is pushed into the FIFO together with a last flag.
- Latency and throughput:
  - First out_valid is high after the 2nd rising edge following the edge that sampled start.
  - Steady state is 1 pixel/clk while out_ready = 1.
- Output:
  - out_data, out_valid and out_last come from the FIFO head.
  - Handshake = out_valid & out_ready pops the head.
  - out_data is stable while out_valid = 1 and out_ready = 0.
- FIFO boundaries:
  - A push and a pop in the same cycle leaves the count unchanged.
  - A push into a full FIFO cannot happen (credit rule); an assertion flags it.
  - A pop from an empty FIFO never happens.
- done rises on the edge of the out_last handshake and stays high until reset. busy falls on the same edge.
- Exactly IMG_W*IMG_H handshakes occur per frame.

Decomposition:
- Shared package rgb2gray_pkg holds:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
  - luma coefficients and the rounding constant 128
  - frame constants: IMG_W, IMG_H, ADDR_W, NUM_PIX = IMG_W*IMG_H
- One sub-module: pix_fifo.
  - Synchronous FIFO, 9-bit entries {last, Y}, depth FIFO_DEPTH, asynchronous active-high reset.
  - Exposes count, full and empty.

Test Plan:
- Plane model R=G=B=100 everywhere, out_ready = 1 -> 16384 outputs, all 100; out_last only on the 16384th; done high one edge later; first out_valid 2 edges after start is sampled.
- Single-channel frames -> R=255 only gives Y=77; G=255 only gives 149; B=255 only gives 29; R=G=B=255 gives 255; all-zero gives 0.
- Raster ramp R=G=B=addr[7:0], out_ready = 1 -> output k equals k mod 256, in order, with no gaps.
- Random out_ready (50% duty) -> same sequence as with out_ready = 1; out_data stable while stalled; FIFO count never exceeds FIFO_DEPTH; rd_addr holds while out of credit.
- out_ready held 0 for 20 cycles early in the frame -> rd_addr stops advancing after 4 issues; exactly 4 buffered outputs; resume loses no pixel.
- Reset asserted at pixel 5000 with out_ready = 1 -> all outputs return to 0 at once; after reset release and start re-asserted, the frame restarts from pixel 0 and completes with exactly 16384 handshakes.

Source files
------------

// File: rtl/rgb2gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb2gray_pkg
// Description : Shared constants and types for the RGB-to-luma streaming
//               stage: frame geometry, luma weights, rounding constant,
//               FIFO sizing and the control FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb2gray_pkg;

   // Frame geometry; plane address is {row, col}, so IMG_W*IMG_H = 2**ADDR_W
   localparam int IMG_W   = 128;
   localparam int IMG_H   = 128;
   localparam int ADDR_W  = 14;
   localparam int NUM_PIX = IMG_W * IMG_H;

   // Pixel/luma sample width and FIFO entry width ({last, Y})
   localparam int PIX_W   = 8;
   localparam int ENTRY_W = PIX_W + 1;

   // Output buffering
   localparam int FIFO_DEPTH = 4;

   // Q0.8 luma weights; they sum to 256 so full-scale grey maps to 255
   localparam int COEF_R     = 77;
   localparam int COEF_G     = 150;
   localparam int COEF_B     = 29;
   localparam int LUMA_ROUND = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rgb2gray_stream_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pix_fifo
// Description : Small synchronous FIFO holding {last, Y} entries between the
//               luma pipeline and the output handshake. Head entry is visible
//               combinationally on o_head (first-word fall-through).
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_push/i_push_data - write strobe and entry
//               i_pop              - remove head entry
//               o_head             - current head entry
//               o_count            - number of stored entries (0..DEPTH)
//               o_full/o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Power-of-two depth: pointers wrap naturally
      if (i_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (i_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged
      case ({i_push, i_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale contents are never observed because
   // the consumer qualifies the head with o_empty.
   always_ff @(posedge clk) begin
      if (i_push) begin
         mem_q[wr_ptr_q] <= i_push_data;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;
   assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
   assign o_empty = (count_q == '0);

   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule
`default_nettype wire

// File: rtl/rgb2gray_stream.sv
`default_nettype none
// ============================================================================
// Module      : rgb2gray_stream
// Description : Scans three filled R/G/B planes in raster order once start
//               is seen, converts every pixel to 8-bit luma through a
//               two-stage pipeline and streams the result over valid/ready.
//               Read issue is credit-gated so the output FIFO can never
//               overflow under backpressure.
// Ports       : clk, reset            - clock, asynchronous active-high reset
//               start                 - level, frame may begin (from demosaic)
//               rd_addr               - shared plane read address {row, col}
//               rdata_r/g/b           - plane data for rd_addr, same cycle
//               out_valid/ready/data  - luma output stream
//               out_last              - marks the final pixel of the frame
//               busy                  - high while RUN or DRAIN
//               done                  - sticky frame-complete flag
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2gray_stream #(
   parameter int IMG_W      = rgb2gray_pkg::IMG_W,
   parameter int IMG_H      = rgb2gray_pkg::IMG_H,
   parameter int ADDR_W     = rgb2gray_pkg::ADDR_W,
   parameter int FIFO_DEPTH = rgb2gray_pkg::FIFO_DEPTH,
   parameter int COEF_R     = rgb2gray_pkg::COEF_R,
   parameter int COEF_G     = rgb2gray_pkg::COEF_G,
   parameter int COEF_B     = rgb2gray_pkg::COEF_B
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic [ADDR_W-1:0]                rd_addr,
   input  logic [rgb2gray_pkg::PIX_W-1:0]   rdata_r,
   input  logic [rgb2gray_pkg::PIX_W-1:0]   rdata_g,
   input  logic [rgb2gray_pkg::PIX_W-1:0]   rdata_b,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [rgb2gray_pkg::PIX_W-1:0]   out_data,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);

   import rgb2gray_pkg::*;

   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W+1)'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

   // S1: registered products plus valid/last tags
   logic                s1_valid_q, s1_valid_d;
   logic                s1_last_q, s1_last_d;
   logic [15:0]         p_r_q, p_r_d;
   logic [15:0]         p_g_q, p_g_d;
   logic [15:0]         p_b_q, p_b_d;

   // ------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------
   logic                issue;
   logic                at_last;
   logic                credit;
   logic [CNT_W:0]      occupancy;
   logic [15:0]         sum;
   logic [PIX_W-1:0]    luma;
   logic                sum_frac_unused;

   logic                fifo_push;
   logic [ENTRY_W-1:0]  fifo_push_data;
   logic                fifo_pop;
   logic [ENTRY_W-1:0]  fifo_head;
   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_full;
   logic                fifo_empty;

   // ------------------------------------------------------------------
   // Credit: FIFO entries plus the item sitting in S1 (which is the entry
   // being written this cycle) must leave room for one more read. Any pixel
   // issued now lands in the FIFO two edges later, by which time at most
   // this many entries can be outstanding.
   // ------------------------------------------------------------------
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
   assign credit    = (occupancy < DEPTH_V);
   assign at_last   = (rd_addr_q == LAST_ADDR);

   // ------------------------------------------------------------------
   // FSM and issue control
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      issue      = 1'b0;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      p_r_d      = p_r_q;
      p_g_d      = p_g_q;
      p_b_d      = p_b_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (credit) begin
               issue = 1'b1;
               // Counter holds at the final address instead of wrapping
               if (at_last) begin
                  state_d = ST_DRAIN;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_pop && fifo_head[PIX_W]) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (issue) begin
         s1_valid_d = 1'b1;
         s1_last_d  = at_last;
         p_r_d      = 16'(rdata_r) * 16'(COEF_R);
         p_g_d      = 16'(rdata_g) * 16'(COEF_G);
         p_b_d      = 16'(rdata_b) * 16'(COEF_B);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rd_addr_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         p_r_q      <= '0;
         p_g_q      <= '0;
         p_b_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         p_r_q      <= p_r_d;
         p_g_q      <= p_g_d;
         p_b_q      <= p_b_d;
      end
   end

   // ------------------------------------------------------------------
   // S2: weighted sum with round-half-up, then drop the fraction.
   // Weights sum to 256, so the worst case is 255*256 + 128 = 65408.
   // ------------------------------------------------------------------
   assign sum             = p_r_q + p_g_q + p_b_q + 16'(LUMA_ROUND);
   assign luma            = sum[15:8];
   assign sum_frac_unused = |sum[7:0];

   assign fifo_push      = s1_valid_q;
   assign fifo_push_data = {s1_last_q, luma};
   assign fifo_pop       = out_valid & out_ready;

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_pix_fifo (
      .clk         (clk),
      .rst         (reset),
      .i_push      (fifo_push),
      .i_push_data (fifo_push_data),
      .i_pop       (fifo_pop),
      .o_head      (fifo_head),
      .o_count     (fifo_count),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Outputs: head of FIFO, forced to zero while empty so that reset and
   // idle both present a clean all-zero stream interface.
   // ------------------------------------------------------------------
   assign out_valid = ~fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_head[PIX_W-1:0];
   assign out_last  = ~fifo_empty & fifo_head[PIX_W];
   assign rd_addr   = rd_addr_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_rgb2gray_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2gray_stream
// Description : Self-checking bench for rgb2gray_stream. Plane memories are
//               modelled as arrays read combinationally at rd_addr; every
//               accepted output is compared against an expected-luma array
//               filled before each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2gray_stream;

   import rgb2gray_pkg::*;

   localparam int NPIX        = NUM_PIX;
   localparam int LAST        = NPIX - 1;
   localparam int DEPTH       = 4;
   localparam int FRAME_LIMIT = 40000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [13:0] rd_addr;
   logic [7:0]  rdata_r, rdata_g, rdata_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [7:0]  plane_r [NPIX];
   logic [7:0]  plane_g [NPIX];
   logic [7:0]  plane_b [NPIX];
   int          exp_y   [NPIX];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int r;
      int g;
      int b;
      int y;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   assign rdata_r = plane_r[rd_addr];
   assign rdata_g = plane_g[rd_addr];
   assign rdata_b = plane_b[rd_addr];

   rgb2gray_stream dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd_addr   (rd_addr),
      .rdata_r   (rdata_r),
      .rdata_g   (rdata_g),
      .rdata_b   (rdata_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // Reference luma: Q0.8 weighted sum, rounded half-up
   function automatic int ref_luma(input int r, input int g, input int b);
      return (77 * r + 150 * g + 29 * b + 128) / 256;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_idle(input string pfx);
      check({pfx, "_rd_addr"},   int'(rd_addr), 0);
      check({pfx, "_out_valid"}, int'(out_valid), 0);
      check({pfx, "_out_data"},  int'(out_data), 0);
      check({pfx, "_out_last"},  int'(out_last), 0);
      check({pfx, "_busy"},      int'(busy), 0);
      check({pfx, "_done"},      int'(done), 0);
   endtask

   // mode 0: out_ready always 1; mode 1: 20-cycle stall then 50% random.
   // abort_at >= 0 asserts reset once that many handshakes are committed.
   task automatic run_frame(input int mode, input int abort_at, output int n_hs);
      int         cycles;
      bit         fin;
      bit         prev_stall;
      logic [7:0] prev_data;
      bit         done_pending;
      n_hs         = 0;
      cycles       = 0;
      fin          = 1'b0;
      prev_stall   = 1'b0;
      prev_data    = '0;
      done_pending = 1'b0;

      @(negedge clk);
      start     = 1'b1;
      out_ready = (mode == 1) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("lat_edge0_valid", int'(out_valid), 0);
      check("lat_edge0_busy",  int'(busy), 1);
      @(posedge clk);
      #1;
      check("lat_edge1_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_edge2_valid", int'(out_valid), 1);

      while (!fin) begin
         @(negedge clk);
         cycles++;
         if (mode == 1) out_ready = (cycles <= 20) ? 1'b0 : ($urandom_range(0, 1) == 1);
         else           out_ready = 1'b1;

         if (cycles > FRAME_LIMIT) begin
            check("frame_timeout", n_hs, NPIX);
            fin = 1'b1;
         end else if (done_pending) begin
            check("done_after_last",  int'(done), 1);
            check("busy_after_last",  int'(busy), 0);
            check("valid_after_last", int'(out_valid), 0);
            fin = 1'b1;
         end else begin
            if (prev_stall) begin
               check("stall_valid", int'(out_valid), 1);
               check("stall_data",  int'(out_data), int'(prev_data));
            end
            if (mode == 1 && cycles >= 4 && cycles <= 20)
               check("credit_hold_addr", int'(rd_addr), DEPTH);
            if (int'(rd_addr) != LAST)
               check("outstanding_le_depth", int'((int'(rd_addr) - n_hs) <= DEPTH), 1);
            if (out_valid && out_ready) begin
               if (n_hs < NPIX) begin
                  check("data", int'(out_data), exp_y[n_hs]);
                  check("last_flag", int'(out_last), int'(n_hs == LAST));
               end else begin
                  check("extra_handshake", n_hs, NPIX - 1);
               end
               n_hs++;
               if (out_last) done_pending = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (abort_at >= 0 && n_hs == abort_at) begin
               reset = 1'b1;
               #1;
               check_idle("abort");
               @(negedge clk);
               @(negedge clk);
               reset = 1'b0;
               fin = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < NPIX; k++) begin
         plane_r[k] = '0;
         plane_g[k] = '0;
         plane_b[k] = '0;
         exp_y[k]   = 0;
      end

      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("idle_no_start");

      // Frame A: table-driven pixel patterns cycled across the frame
      vecs[0] = '{255,   0,   0,  77};
      vecs[1] = '{  0, 255,   0, 149};
      vecs[2] = '{  0,   0, 255,  29};
      vecs[3] = '{255, 255, 255, 255};
      vecs[4] = '{  0,   0,   0,   0};
      vecs[5] = '{100, 100, 100, 100};
      vecs[6] = '{ 10,  20,  30,  18};
      vecs[7] = '{200, 100,  50, 124};
      for (int k = 0; k < NPIX; k++) begin
         plane_r[k] = 8'(vecs[k % 8].r);
         plane_g[k] = 8'(vecs[k % 8].g);
         plane_b[k] = 8'(vecs[k % 8].b);
         exp_y[k]   = vecs[k % 8].y;
      end
      run_frame(0, -1, n);
      check("frameA_handshakes", n, NPIX);

      // start is ignored once DONE
      @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("done_sticky",        int'(done), 1);
      check("done_no_restart",    int'(out_valid), 0);
      check("done_busy_low",      int'(busy), 0);
      check("done_rd_addr_holds", int'(rd_addr), LAST);
      start = 1'b0;

      reset = 1'b1;
      #1;
      check_idle("reset_after_done");
      @(negedge clk);
      reset = 1'b0;

      // Frame B: random planes, random backpressure
      for (int k = 0; k < NPIX; k++) begin
         plane_r[k] = 8'($urandom_range(0, 255));
         plane_g[k] = 8'($urandom_range(0, 255));
         plane_b[k] = 8'($urandom_range(0, 255));
         exp_y[k]   = ref_luma(int'(plane_r[k]), int'(plane_g[k]), int'(plane_b[k]));
      end
      run_frame(1, -1, n);
      check("frameB_handshakes", n, NPIX);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Frames C/D: raster ramp, aborted at pixel 5000 then rerun in full
      for (int k = 0; k < NPIX; k++) begin
         plane_r[k] = 8'(k % 256);
         plane_g[k] = 8'(k % 256);
         plane_b[k] = 8'(k % 256);
         exp_y[k]   = k % 256;
      end
      run_frame(0, 5000, n);
      check("frameC_abort_handshakes", n, 5000);
      @(negedge clk);
      check_idle("post_abort");
      run_frame(0, -1, n);
      check("frameD_handshakes", n, NPIX);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
